// File: rtl/xup_and_pkg.sv
// Shared definitions for the two-lane AND response checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xup_and_pkg;

    // Checker control states; encodings are fixed so on-board probes can decode them.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Deepest DUT response delay the checker can align against.
    localparam int LATENCY_MAX = 7;

    // Width of the drain down-counter, sized for LATENCY_MAX.
    localparam int DRAIN_W = $clog2(LATENCY_MAX + 1);

endpackage

// File: rtl/xup_and_checker_delay.sv
// Valid+data delay line that holds expected responses until the DUT answers.
// Latency: DEPTH cycles; DEPTH=0 is a combinational pass-through.
// Backpressure: none, shifts every cycle; clr_i drops all in-flight valid bits.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clr_i               synchronous clear of every stage's valid bit
//   in_vld_i, in_dat_i  entry into stage 0
//   out_vld_o, out_dat_o  last stage (or the input when DEPTH=0)
module xup_delay_line #(
    parameter int DW    = 4,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          in_vld_i,
    input  logic [DW-1:0] in_dat_i,
    output logic          out_vld_o,
    output logic [DW-1:0] out_dat_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Combinational DUT: the expected word is compared in the cycle it is presented.
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst, clr_i};
            assign out_vld_o  = in_vld_i;
            assign out_dat_o  = in_dat_i;
        end else begin : g_pipe
            logic [DEPTH-1:0]         vld_q;
            logic [DEPTH-1:0][DW-1:0] dat_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                    dat_q <= '0;
                end else begin
                    // Data is don't-care behind a clear valid bit, so only valids are cleared.
                    vld_q[0] <= in_vld_i & ~clr_i;
                    dat_q[0] <= in_dat_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        vld_q[i] <= vld_q[i-1] & ~clr_i;
                        dat_q[i] <= dat_q[i-1];
                    end
                end
            end

            assign out_vld_o = vld_q[DEPTH-1];
            assign out_dat_o = dat_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/xup_and_checker.sv
// Response checker for the two-lane AND system: aligns expected ANDs to DUT responses and counts mismatches.
// Latency: expected word delayed LATENCY cycles; counters/flags update one edge after each compare.
// Backpressure: none; stimulus is observed, never stalled. DRAIN lasts exactly LATENCY cycles.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   start, stop                 run control pulses
//   vec_valid, a_*, b_*         observed stimulus
//   y_0, y_1                    observed DUT response
//   busy, done, pass            status (registered)
//   vec_cnt, err_cnt            saturating vector / mismatch counters
//   first_err_idx/_exp/_got     snapshot of the first mismatching vector
import xup_and_pkg::*;

module xup_and_checker #(
    parameter int WIDTH   = 3,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             vec_valid,
    input  logic             a_0,
    input  logic             b_0,
    input  logic [WIDTH-1:0] a_1,
    input  logic [WIDTH-1:0] b_1,
    input  logic             y_0,
    input  logic [WIDTH-1:0] y_1,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH:0]   first_err_exp,
    output logic [WIDTH:0]   first_err_got
);

    localparam logic [DRAIN_W-1:0] DRAIN_INIT =
        (LATENCY == 0) ? '0 : DRAIN_W'(LATENCY - 1);

    state_t               state_q;
    logic [DRAIN_W-1:0]   drain_q;
    logic                 busy_q, done_q, pass_q;
    logic [CNT_W-1:0]     vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]     fidx_q, fidx_d;
    logic [WIDTH:0]       fexp_q, fexp_d;
    logic [WIDTH:0]       fgot_q, fgot_d;

    logic                 clear_run;
    logic                 pipe_in_vld;
    logic                 cmp_vld;
    logic [WIDTH:0]       exp_w;
    logic [WIDTH:0]       got_w;
    logic                 mismatch;

    // start only acts from IDLE/DONE and then also wins over a simultaneous stop.
    assign clear_run   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign pipe_in_vld = (state_q == S_RUN) && vec_valid;

    xup_delay_line #(
        .DW    (WIDTH + 1),
        .DEPTH (LATENCY)
    ) u_exp_pipe (
        .clk       (clk),
        .rst       (reset),
        .clr_i     (clear_run),
        .in_vld_i  (pipe_in_vld),
        .in_dat_i  ({a_1 & b_1, a_0 & b_0}),
        .out_vld_o (cmp_vld),
        .out_dat_o (exp_w)
    );

    assign got_w = {y_1, y_0};
    // Case inequality so an X/Z response is reported as a mismatch in simulation.
    assign mismatch = (got_w !== exp_w);

    always_comb begin
        vec_cnt_d = vec_cnt_q;
        err_cnt_d = err_cnt_q;
        fidx_d    = fidx_q;
        fexp_d    = fexp_q;
        fgot_d    = fgot_q;
        if (clear_run) begin
            vec_cnt_d = '0;
            err_cnt_d = '0;
            fidx_d    = '0;
            fexp_d    = '0;
            fgot_d    = '0;
        end else if (cmp_vld) begin
            if (!(&vec_cnt_q)) vec_cnt_d = vec_cnt_q + 1'b1;
            if (mismatch) begin
                if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
                // Only the first mismatch of a run is captured; index is 0-based.
                if (err_cnt_q == '0) begin
                    fidx_d = vec_cnt_q;
                    fexp_d = exp_w;
                    fgot_d = got_w;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            vec_cnt_q <= '0;
            err_cnt_q <= '0;
            fidx_q    <= '0;
            fexp_q    <= '0;
            fgot_q    <= '0;
        end else begin
            vec_cnt_q <= vec_cnt_d;
            err_cnt_q <= err_cnt_d;
            fidx_q    <= fidx_d;
            fexp_q    <= fexp_d;
            fgot_q    <= fgot_d;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        if (LATENCY == 0) begin
                            // Nothing in flight: the stop-cycle vector is compared this cycle.
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_cnt_d == '0);
                        end else begin
                            state_q <= S_DRAIN;
                            drain_q <= DRAIN_INIT;
                        end
                    end
                end
                S_DRAIN: begin
                    // The last in-flight vector is compared in the final DRAIN cycle, so
                    // pass must look at the count that lands on this same edge.
                    if (drain_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == '0);
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign vec_cnt       = vec_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = fidx_q;
    assign first_err_exp = fexp_q;
    assign first_err_got = fgot_q;

endmodule

// File: tb/tb_xup_and_checker.sv
// Bench for xup_and_checker: four checker instances (LATENCY 1/3/1/0, one with CNT_W=4),
// each fed by an ideal AND DUT model with per-vector fault injection.
// Expected results come from a vector-level scoreboard of the accepted stream.
module tb_xup_and_checker;

    localparam int NDUT = 4;
    localparam int LAT  [NDUT] = '{1, 3, 1, 0};
    localparam int CMAX [NDUT] = '{65535, 65535, 15, 65535};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst;
    logic                      a_0, b_0;
    logic [2:0]                a_1, b_1;
    logic [NDUT-1:0]           start_s, stop_s, vv_s;
    logic [NDUT-1:0][3:0]      fmask;
    logic [NDUT-1:0][3:0]      y_w;
    logic [3:0]                hist [NDUT][4];

    logic [NDUT-1:0]           busy_w, done_w, pass_w;
    logic [NDUT-1:0][15:0]     vc_w, ec_w, fi_w;
    logic [NDUT-1:0][3:0]      fe_w, fg_w;
    logic [3:0]                vc2, ec2, fi2;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard of the current run.
    int         m_vec, m_err, m_fidx, m_max;
    logic [3:0] m_fexp, m_fgot;
    bit         m_run;

    // Ideal registered AND DUTs; the fault mask travels with its vector.
    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 3; i > 0; i--) hist[k][i] <= hist[k][i-1];
            hist[k][0] <= {a_1 & b_1, a_0 & b_0} ^ fmask[k];
        end
    end
    assign y_w[0] = hist[0][0];
    assign y_w[1] = hist[1][2];
    assign y_w[2] = hist[2][0];
    assign y_w[3] = {a_1 & b_1, a_0 & b_0} ^ fmask[3];

    xup_and_checker #(.WIDTH(3), .LATENCY(1), .CNT_W(16)) u_d0 (
        .clk(clk), .reset(rst), .start(start_s[0]), .stop(stop_s[0]), .vec_valid(vv_s[0]),
        .a_0(a_0), .b_0(b_0), .a_1(a_1), .b_1(b_1), .y_0(y_w[0][0]), .y_1(y_w[0][3:1]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .vec_cnt(vc_w[0]), .err_cnt(ec_w[0]),
        .first_err_idx(fi_w[0]), .first_err_exp(fe_w[0]), .first_err_got(fg_w[0]));

    xup_and_checker #(.WIDTH(3), .LATENCY(3), .CNT_W(16)) u_d1 (
        .clk(clk), .reset(rst), .start(start_s[1]), .stop(stop_s[1]), .vec_valid(vv_s[1]),
        .a_0(a_0), .b_0(b_0), .a_1(a_1), .b_1(b_1), .y_0(y_w[1][0]), .y_1(y_w[1][3:1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .vec_cnt(vc_w[1]), .err_cnt(ec_w[1]),
        .first_err_idx(fi_w[1]), .first_err_exp(fe_w[1]), .first_err_got(fg_w[1]));

    xup_and_checker #(.WIDTH(3), .LATENCY(1), .CNT_W(4)) u_d2 (
        .clk(clk), .reset(rst), .start(start_s[2]), .stop(stop_s[2]), .vec_valid(vv_s[2]),
        .a_0(a_0), .b_0(b_0), .a_1(a_1), .b_1(b_1), .y_0(y_w[2][0]), .y_1(y_w[2][3:1]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .vec_cnt(vc2), .err_cnt(ec2),
        .first_err_idx(fi2), .first_err_exp(fe_w[2]), .first_err_got(fg_w[2]));
    assign vc_w[2] = {12'd0, vc2};
    assign ec_w[2] = {12'd0, ec2};
    assign fi_w[2] = {12'd0, fi2};

    xup_and_checker #(.WIDTH(3), .LATENCY(0), .CNT_W(16)) u_d3 (
        .clk(clk), .reset(rst), .start(start_s[3]), .stop(stop_s[3]), .vec_valid(vv_s[3]),
        .a_0(a_0), .b_0(b_0), .a_1(a_1), .b_1(b_1), .y_0(y_w[3][0]), .y_1(y_w[3][3:1]),
        .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .vec_cnt(vc_w[3]), .err_cnt(ec_w[3]),
        .first_err_idx(fi_w[3]), .first_err_exp(fe_w[3]), .first_err_got(fg_w[3]));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_start(input int k);
        m_vec = 0; m_err = 0; m_fidx = 0; m_fexp = '0; m_fgot = '0;
        m_max = CMAX[k]; m_run = 1'b1;
    endtask

    task automatic model_push(input logic [3:0] exp, input logic [3:0] got);
        if (got != exp) begin
            if (m_err == 0) begin
                m_fidx = m_vec; m_fexp = exp; m_fgot = got;
            end
            if (m_err < m_max) m_err++;
        end
        if (m_vec < m_max) m_vec++;
    endtask

    // Start pulse (optionally with a simultaneous stop); begins a new scoreboard run.
    task automatic pulse_start(input int k, input bit with_stop);
        start_s[k] = 1'b1;
        stop_s[k]  = with_stop;
        tick();
        start_s[k] = 1'b0;
        stop_s[k]  = 1'b0;
        model_start(k);
    endtask

    // One stimulus cycle to checker k; fm is the fault applied to this vector's response.
    task automatic step(input int k, input bit v, input bit st, input logic a0, input logic b0,
                        input logic [2:0] a1, input logic [2:0] b1, input logic [3:0] fm);
        a_0 = a0; b_0 = b0; a_1 = a1; b_1 = b1;
        vv_s[k] = v; stop_s[k] = st; fmask[k] = fm;
        if (m_run && v) model_push({a1 & b1, a0 & b0}, {a1 & b1, a0 & b0} ^ fm);
        if (st) m_run = 1'b0;
        tick();
        vv_s[k] = 1'b0; stop_s[k] = 1'b0; fmask[k] = '0;
    endtask

    task automatic wait_done(input int k, output int cyc, output bit ok);
        cyc = 0;
        while (!done_w[k] && cyc < 20) begin
            tick();
            cyc++;
        end
        ok = done_w[k];
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy_w, done_w, pass_w} !== '0) begin
            n_errors++; $display("FAIL reset_status: got %b required 0", {busy_w, done_w, pass_w});
        end
        n_checks++;
        if ({vc_w, ec_w, fi_w} !== '0) begin
            n_errors++; $display("FAIL reset_counters: got %h required 0", {vc_w, ec_w, fi_w});
        end
        n_checks++;
        if ({fe_w, fg_w} !== '0) begin
            n_errors++; $display("FAIL reset_first_err: got %h required 0", {fe_w, fg_w});
        end
    endtask

    task automatic test_basic();
        int cyc; bit ok;
        logic [2:0] a1, b1;
        pulse_start(0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            a1 = (i == 0) ? 3'd3 : (i == 1) ? 3'd1 : 3'($urandom_range(0, 7));
            b1 = (i == 0) ? 3'd1 : (i == 1) ? 3'd3 : 3'($urandom_range(0, 7));
            step(0, 1'b1, i == 9, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a1, b1, 4'd0);
        end
        n_checks++;
        if (busy_w[0] !== 1'b1 || done_w[0] !== 1'b0) begin
            n_errors++; $display("FAIL basic_drain_state: busy=%b done=%b required busy=1 done=0", busy_w[0], done_w[0]);
        end
        wait_done(0, cyc, ok);
        n_checks++;
        if (!ok || cyc != 1) begin
            n_errors++; $display("FAIL basic_drain_len: got %0d cycles (done=%b) required 1", cyc, ok);
        end
        n_checks++;
        if (vc_w[0] !== 16'd10 || ec_w[0] !== 16'd0 || pass_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            n_errors++; $display("FAIL basic_result: vec=%0d err=%0d pass=%b busy=%b required 10 0 1 0",
                                 vc_w[0], ec_w[0], pass_w[0], busy_w[0]);
        end
    endtask

    task automatic test_first_error();
        int cyc; bit ok;
        pulse_start(0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) step(0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 3'd1, 4'b0010);
            else        step(0, 1'b1, i == 9, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 4'd0);
        end
        wait_done(0, cyc, ok);
        n_checks++;
        if (!ok || ec_w[0] !== 16'd1 || pass_w[0] !== 1'b0) begin
            n_errors++; $display("FAIL ferr_count: done=%b err=%0d pass=%b required 1 1 0", ok, ec_w[0], pass_w[0]);
        end
        n_checks++;
        if (fi_w[0] !== 16'd4 || fe_w[0] !== 4'b0010 || fg_w[0] !== 4'b0000) begin
            n_errors++; $display("FAIL ferr_capture: idx=%0d exp=%b got=%b required 4 0010 0000",
                                 fi_w[0], fe_w[0], fg_w[0]);
        end
    endtask

    task automatic test_bubble();
        int cyc; bit ok;
        pulse_start(1, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1, i != 2, i == 3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 4'd0);
        wait_done(1, cyc, ok);
        n_checks++;
        if (!ok || cyc != 3) begin
            n_errors++; $display("FAIL bubble_drain_len: got %0d cycles (done=%b) required 3", cyc, ok);
        end
        n_checks++;
        if (vc_w[1] !== 16'd3 || ec_w[1] !== 16'd0 || pass_w[1] !== 1'b1) begin
            n_errors++; $display("FAIL bubble_result: vec=%0d err=%0d pass=%b required 3 0 1", vc_w[1], ec_w[1], pass_w[1]);
        end
    endtask

    task automatic test_saturate();
        int cyc; bit ok;
        logic a0, b0; logic [2:0] a1, b1;
        logic [3:0] first_exp;
        first_exp = '0;
        pulse_start(2, 1'b0);
        for (int i = 0; i < 20; i++) begin
            a0 = 1'($urandom_range(0, 1)); b0 = 1'($urandom_range(0, 1));
            a1 = 3'($urandom_range(0, 7)); b1 = 3'($urandom_range(0, 7));
            if (i == 0) first_exp = {a1 & b1, a0 & b0};
            step(2, 1'b1, i == 19, a0, b0, a1, b1, 4'b0001);
        end
        wait_done(2, cyc, ok);
        n_checks++;
        if (!ok || vc_w[2] !== 16'd15 || ec_w[2] !== 16'd15) begin
            n_errors++; $display("FAIL sat_counts: done=%b vec=%0d err=%0d required 1 15 15", ok, vc_w[2], ec_w[2]);
        end
        n_checks++;
        if (fi_w[2] !== 16'd0 || fe_w[2] !== first_exp || fg_w[2] !== (first_exp ^ 4'b0001) || pass_w[2] !== 1'b0) begin
            n_errors++; $display("FAIL sat_first_err: idx=%0d exp=%b got=%b pass=%b required 0 %b %b 0",
                                 fi_w[2], fe_w[2], fg_w[2], pass_w[2], first_exp, first_exp ^ 4'b0001);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc; bit ok;
        pulse_start(0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 3'd5, (i == 2) ? 4'b1000 : 4'd0);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy_w[0], done_w[0], pass_w[0]} !== 3'b000 || vc_w[0] !== 16'd0 || ec_w[0] !== 16'd0) begin
            n_errors++; $display("FAIL midrst_outputs: busy=%b done=%b pass=%b vec=%0d err=%0d required all 0",
                                 busy_w[0], done_w[0], pass_w[0], vc_w[0], ec_w[0]);
        end
        tick();
        rst = 1'b0;
        m_run = 1'b0;
        tick();
        n_checks++;
        if (busy_w[0] !== 1'b0 || vc_w[0] !== 16'd0) begin
            n_errors++; $display("FAIL midrst_idle: busy=%b vec=%0d required 0 0", busy_w[0], vc_w[0]);
        end
        pulse_start(0, 1'b0);
        step(0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 3'd3, 4'd0);
        step(0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 3'd7, 4'd0);
        wait_done(0, cyc, ok);
        n_checks++;
        if (!ok || vc_w[0] !== 16'd2 || ec_w[0] !== 16'd0 || pass_w[0] !== 1'b1) begin
            n_errors++; $display("FAIL midrst_rerun: done=%b vec=%0d err=%0d pass=%b required 1 2 0 1",
                                 ok, vc_w[0], ec_w[0], pass_w[0]);
        end
    endtask

    task automatic test_comb_restart();
        int cyc; bit ok;
        pulse_start(3, 1'b0);
        for (int i = 0; i < 4; i++)
            step(3, 1'b1, i == 3, 1'b1, 1'b1, 3'($urandom_range(0, 7)), 3'd7, (i == 1) ? 4'b0100 : 4'd0);
        n_checks++;
        if (done_w[3] !== 1'b1 || busy_w[3] !== 1'b0 || vc_w[3] !== 16'd4 || ec_w[3] !== 16'd1 || fi_w[3] !== 16'd1) begin
            n_errors++; $display("FAIL comb_first_run: done=%b busy=%b vec=%0d err=%0d idx=%0d required 1 0 4 1 1",
                                 done_w[3], busy_w[3], vc_w[3], ec_w[3], fi_w[3]);
        end
        pulse_start(3, 1'b1);
        n_checks++;
        if (busy_w[3] !== 1'b1 || done_w[3] !== 1'b0 || vc_w[3] !== 16'd0 || ec_w[3] !== 16'd0 ||
            {fi_w[3], fe_w[3], fg_w[3]} !== '0) begin
            n_errors++; $display("FAIL comb_start_stop: busy=%b done=%b vec=%0d err=%0d idx=%0d required 1 0 0 0 0",
                                 busy_w[3], done_w[3], vc_w[3], ec_w[3], fi_w[3]);
        end
        for (int i = 0; i < 3; i++)
            step(3, 1'b1, i == 2, 1'($urandom_range(0, 1)), 1'b1, 3'($urandom_range(0, 7)), 3'd2, 4'd0);
        n_checks++;
        if (done_w[3] !== 1'b1 || vc_w[3] !== 16'd3 || pass_w[3] !== 1'b1) begin
            n_errors++; $display("FAIL comb_direct_done: done=%b vec=%0d pass=%b required 1 3 1", done_w[3], vc_w[3], pass_w[3]);
        end
    endtask

    task automatic test_random();
        int cyc; bit ok; int n;
        for (int k = 0; k < NDUT; k++) begin
            for (int r = 0; r < 3; r++) begin
                pulse_start(k, 1'b0);
                n = $urandom_range(4, 24);
                for (int i = 0; i < n; i++)
                    step(k, $urandom_range(0, 9) < 7, i == n - 1,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                         ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0);
                wait_done(k, cyc, ok);
                n_checks++;
                if (!ok || cyc != LAT[k]) begin
                    n_errors++; $display("FAIL rand_drain d%0d: got %0d cycles (done=%b) required %0d", k, cyc, ok, LAT[k]);
                end
                n_checks++;
                if (vc_w[k] !== 16'(m_vec) || ec_w[k] !== 16'(m_err) || pass_w[k] !== (m_err == 0)) begin
                    n_errors++; $display("FAIL rand_counts d%0d: vec=%0d err=%0d pass=%b required %0d %0d %b",
                                         k, vc_w[k], ec_w[k], pass_w[k], m_vec, m_err, m_err == 0);
                end
                n_checks++;
                if (fi_w[k] !== 16'(m_fidx) || fe_w[k] !== m_fexp || fg_w[k] !== m_fgot) begin
                    n_errors++; $display("FAIL rand_first_err d%0d: idx=%0d exp=%b got=%b required %0d %b %b",
                                         k, fi_w[k], fe_w[k], fg_w[k], m_fidx, m_fexp, m_fgot);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a_0 = 1'b0; b_0 = 1'b0; a_1 = '0; b_1 = '0;
        start_s = '0; stop_s = '0; vv_s = '0; fmask = '0;
        m_run = 1'b0; m_vec = 0; m_err = 0; m_fidx = 0; m_max = 0; m_fexp = '0; m_fgot = '0;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_basic();
        test_first_error();
        test_bubble();
        test_saturate();
        test_reset_mid_run();
        test_comb_restart();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
